// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared pipeline package for the memory-port arbiter slice. Holds the
// arbiter state encoding, the default MEM burst limit before fetch is forced
// through, and a helper that sizes the starvation counter.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Arbiter states: IDLE between accesses, otherwise one grant is in flight
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } arbState_e;

  localparam int MAX_MEM_BURST_DEFAULT = 4;

  // Bits needed to hold a count from 0 up to and including maxBurst
  function automatic int starveCntWidth(input int maxBurst);
    return (maxBurst < 1) ? 1 : $clog2(maxBurst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses around the arbiter:
//   IF_*  : instruction-fetch requester (Req/Addr in, Valid/Data/Stall out)
//   MEM_* : data-stage requester (Req/Write/Addr/WData in, Valid/Data/Stall out)
//   Mem_* : single-port memory (Req/Write/Addr/WData out, RData/Ready in)
// Modport slave is the arbiter's view; modport master is the environment's
// view (pipeline stages plus memory) and drives what the arbiter samples.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  logic        IF_Req;
  logic [31:0] IF_Addr;
  logic        IF_Valid;
  logic [31:0] IF_Data;
  logic        IF_Stall;

  logic        MEM_Req;
  logic        MEM_Write;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_WData;
  logic        MEM_Valid;
  logic [31:0] MEM_Data;
  logic        MEM_Stall;

  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Mem_Ready;

  modport slave (
    input  IF_Req, IF_Addr,
    input  MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
    input  Mem_RData, Mem_Ready,
    output IF_Valid, IF_Data, IF_Stall,
    output MEM_Valid, MEM_Data, MEM_Stall,
    output Mem_Req, Mem_Write, Mem_Addr, Mem_WData
  );

  modport master (
    output IF_Req, IF_Addr,
    output MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
    output Mem_RData, Mem_Ready,
    input  IF_Valid, IF_Data, IF_Stall,
    input  MEM_Valid, MEM_Data, MEM_Stall,
    input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive MEM grants taken while fetch was waiting. Saturates at
// MAX_COUNT so the arbiter can compare against the limit without wrapping.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   incr_i       : count one more starved grant (saturating)
//   clear_i      : restart from zero (wins over incr_i)
//   count_o      : current count
// -----------------------------------------------------------------------------
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_COUNT = MAX_MEM_BURST_DEFAULT,
  parameter int CNT_W     = starveCntWidth(MAX_COUNT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             incr_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority, increment stops at the limit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != MaxCnt)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the data
// stage (MEM). MEM normally wins a tie, but once MAX_MEM_BURST MEM grants have
// been taken while fetch waited, fetch gets the next grant. The winner's
// address, write data and write flag are latched at grant time and drive the
// memory until Mem_Ready completes the access; every access is followed by one
// IDLE cycle.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : mem_port_arbiter_if.slave (IF_*, MEM_* and Mem_* buses)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_MEM_BURST = MAX_MEM_BURST_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam int               CNT_W      = starveCntWidth(MAX_MEM_BURST);
  localparam logic [CNT_W-1:0] BurstLimit = CNT_W'(MAX_MEM_BURST);

  arbState_e        state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [CNT_W-1:0] starveCnt;
  logic             grantIf, grantMem;
  logic             ifValid, memValid;

  // Next-state and grant decision. Ties go to MEM unless fetch has been
  // starved for the full burst. Mem_Ready seen in IDLE is ignored because
  // only the grant states look at it. The write flag drops when an access
  // completes so Mem_Write never lingers into IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    grantIf  = 1'b0;
    grantMem = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.IF_Req && (!bus.MEM_Req || (starveCnt == BurstLimit))) begin
          grantIf = 1'b1;
          state_d = GRANT_IF;
          addr_d  = bus.IF_Addr;
          wdata_d = '0;
          write_d = 1'b0;
        end else if (bus.MEM_Req) begin
          grantMem = 1'b1;
          state_d  = GRANT_MEM;
          addr_d   = bus.MEM_Addr;
          wdata_d  = bus.MEM_WData;
          write_d  = bus.MEM_Write;
        end
      end
      GRANT_IF, GRANT_MEM: begin
        if (bus.Mem_Ready) begin
          state_d = IDLE;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and access latches. Reset abandons any access in flight at once,
  // which also drops Mem_Req without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Starvation tracking: a MEM grant while fetch waits adds one, any other
  // grant restarts the count
  arb_starve_counter #(
    .MAX_COUNT (MAX_MEM_BURST),
    .CNT_W     (CNT_W)
  ) u_starve (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .incr_i  (grantMem && bus.IF_Req),
    .clear_i (grantIf || (grantMem && !bus.IF_Req)),
    .count_o (starveCnt)
  );

  // Completion pulses are combinational so Valid lands in the same cycle
  // that Mem_Ready arrives
  assign ifValid  = (state_q == GRANT_IF)  && bus.Mem_Ready;
  assign memValid = (state_q == GRANT_MEM) && bus.Mem_Ready;

  assign bus.Mem_Req   = (state_q != IDLE);
  assign bus.Mem_Write = write_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_WData = wdata_q;

  assign bus.IF_Valid  = ifValid;
  assign bus.IF_Data   = bus.Mem_RData;
  assign bus.IF_Stall  = bus.IF_Req && !ifValid;

  assign bus.MEM_Valid = memValid;
  assign bus.MEM_Data  = bus.Mem_RData;
  assign bus.MEM_Stall = bus.MEM_Req && !memValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with MAX_MEM_BURST = 4. Inputs change
// and outputs are sampled on the falling clock edge; the design acts on the
// rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   peakStarve;
  logic expIf;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_MEM_BURST (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every environment-side input in one go
  task automatic applyStimulus(
    input logic        ifReq,
    input logic [31:0] ifAddr,
    input logic        memReq,
    input logic        memWrite,
    input logic [31:0] memAddr,
    input logic [31:0] memWData,
    input logic [31:0] rdata,
    input logic        ready
  );
    bus.IF_Req    = ifReq;
    bus.IF_Addr   = ifAddr;
    bus.MEM_Req   = memReq;
    bus.MEM_Write = memWrite;
    bus.MEM_Addr  = memAddr;
    bus.MEM_WData = memWData;
    bus.Mem_RData = rdata;
    bus.Mem_Ready = ready;
  endtask

  // Word-wide comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Single-bit comparison
  task automatic checkFlag(input string tag, input logic observed,
                           input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    peakStarve  = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset state
    tick();
    #1;
    checkFlag("rst_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("rst_mem_write", bus.Mem_Write, 1'b0);
    checkFlag("rst_if_valid", bus.IF_Valid, 1'b0);
    checkFlag("rst_mem_valid", bus.MEM_Valid, 1'b0);
    checkOutput("rst_mem_addr", bus.Mem_Addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.Mem_WData, 32'h0);
    checkOutput("rst_starve", 32'(dut.starveCnt), 32'd0);
    rst = 1'b0;

    // Single fetch, Ready after two grant cycles
    tick();
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_2222, 1'b0);
    #1;
    checkFlag("if1_idle_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("if1_idle_stall", bus.IF_Stall, 1'b1);
    tick();
    #1;
    checkFlag("if1_c1_mem_req", bus.Mem_Req, 1'b1);
    checkOutput("if1_c1_addr", bus.Mem_Addr, 32'h0000_0040);
    checkFlag("if1_c1_write", bus.Mem_Write, 1'b0);
    checkFlag("if1_c1_valid", bus.IF_Valid, 1'b0);
    checkFlag("if1_c1_stall", bus.IF_Stall, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0040, 1'b1);
    #1;
    checkFlag("if1_c2_mem_req", bus.Mem_Req, 1'b1);
    checkFlag("if1_c2_valid", bus.IF_Valid, 1'b1);
    checkOutput("if1_c2_data", bus.IF_Data, 32'hCAFE_0040);
    checkFlag("if1_c2_stall", bus.IF_Stall, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkFlag("if1_after_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("if1_after_valid", bus.IF_Valid, 1'b0);
    checkFlag("if1_after_stall", bus.IF_Stall, 1'b0);

    // Both request: MEM store goes first, fetch after one IDLE cycle
    tick();
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    #1;
    checkFlag("tie_idle_if_stall", bus.IF_Stall, 1'b1);
    checkFlag("tie_idle_mem_stall", bus.MEM_Stall, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b1);
    #1;
    checkFlag("tie_mem_req", bus.Mem_Req, 1'b1);
    checkFlag("tie_mem_write", bus.Mem_Write, 1'b1);
    checkOutput("tie_mem_addr", bus.Mem_Addr, 32'h0000_0100);
    checkOutput("tie_mem_wdata", bus.Mem_WData, 32'hDEAD_BEEF);
    checkFlag("tie_mem_valid", bus.MEM_Valid, 1'b1);
    checkFlag("tie_if_valid", bus.IF_Valid, 1'b0);
    checkFlag("tie_mem_stall", bus.MEM_Stall, 1'b0);
    checkFlag("tie_if_stall", bus.IF_Stall, 1'b1);
    checkOutput("tie_starve", 32'(dut.starveCnt), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkFlag("tie_gap_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("tie_gap_if_valid", bus.IF_Valid, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b1);
    #1;
    checkFlag("tie_if_mem_req", bus.Mem_Req, 1'b1);
    checkFlag("tie_if_write", bus.Mem_Write, 1'b0);
    checkOutput("tie_if_addr", bus.Mem_Addr, 32'h0000_0080);
    checkFlag("tie_if_valid2", bus.IF_Valid, 1'b1);
    checkOutput("tie_if_data", bus.IF_Data, 32'h0BAD_F00D);
    checkOutput("tie_if_starve", 32'(dut.starveCnt), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Continuous contention, Ready always high: MEM x4 then IF, repeating
    tick();
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 1'b1);
    for (int g = 0; g < 10; g++) begin
      tick();
      #1;
      expIf = ((g % 5) == 4);
      checkFlag("burst_mem_req", bus.Mem_Req, 1'b1);
      checkFlag("burst_if_valid", bus.IF_Valid, expIf);
      checkFlag("burst_mem_valid", bus.MEM_Valid, !expIf);
      checkOutput("burst_addr", bus.Mem_Addr, expIf ? 32'h0000_0200 : 32'h0000_0300);
      checkOutput("burst_starve", 32'(dut.starveCnt), expIf ? 32'd0 : 32'((g % 5) + 1));
      if (32'(dut.starveCnt) > peakStarve) begin
        peakStarve = 32'(dut.starveCnt);
      end
      tick();
      #1;
      checkFlag("burst_gap_mem_req", bus.Mem_Req, 1'b0);
    end
    checkOutput("burst_peak_starve", 32'(peakStarve), 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset in the middle of a MEM grant, then regrant the pending request
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b0);
    tick();
    #1;
    checkFlag("rstg_mem_req", bus.Mem_Req, 1'b1);
    checkOutput("rstg_addr", bus.Mem_Addr, 32'h0000_0400);
    #1;
    rst = 1'b1;
    bus.Mem_Ready = 1'b1;
    #1;
    checkFlag("rstg_async_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("rstg_no_valid", bus.MEM_Valid, 1'b0);
    checkFlag("rstg_write", bus.Mem_Write, 1'b0);
    checkOutput("rstg_addr_clr", bus.Mem_Addr, 32'h0);
    tick();
    rst = 1'b0;
    bus.Mem_Ready = 1'b0;
    #1;
    checkFlag("rstg_rel_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("rstg_rel_stall", bus.MEM_Stall, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1);
    #1;
    checkFlag("rstg_regrant_req", bus.Mem_Req, 1'b1);
    checkOutput("rstg_regrant_addr", bus.Mem_Addr, 32'h0000_0400);
    checkFlag("rstg_regrant_valid", bus.MEM_Valid, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Ready in IDLE is ignored; fetch dropping Req mid-grant still completes
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_7777, 1'b1);
    #1;
    checkFlag("idle_rdy_if_valid", bus.IF_Valid, 1'b0);
    checkFlag("idle_rdy_mem_valid", bus.MEM_Valid, 1'b0);
    tick();
    #1;
    checkFlag("idle_rdy_mem_req", bus.Mem_Req, 1'b0);
    checkFlag("idle_rdy_if_valid2", bus.IF_Valid, 1'b0);
    applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checkFlag("drop_mem_req", bus.Mem_Req, 1'b1);
    checkOutput("drop_addr", bus.Mem_Addr, 32'h0000_0600);
    checkFlag("drop_stall", bus.IF_Stall, 1'b0);
    checkFlag("drop_no_valid_yet", bus.IF_Valid, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h600D_CAFE, 1'b1);
    #1;
    checkFlag("drop_valid", bus.IF_Valid, 1'b1);
    checkOutput("drop_data", bus.IF_Data, 32'h600D_CAFE);
    tick();
    #1;
    checkFlag("drop_single_pulse", bus.IF_Valid, 1'b0);
    checkFlag("drop_done_mem_req", bus.Mem_Req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
